// File: rtl/fetch_queue_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the IF->ID
// valid/ready handshake. The fetch unit is the master side.
interface fetch_queue_unit_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
);
    logic             imem_rd_en;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_data;
    logic             id_valid;
    logic             id_ready;
    logic [PC_W-1:0]  id_pc;
    logic [INS_W-1:0] id_instr;

    modport master (
        output imem_rd_en, imem_addr,
        input  imem_data,
        output id_valid, id_pc, id_instr,
        input  id_ready
    );

    modport slave (
        input  imem_rd_en, imem_addr,
        output imem_data,
        input  id_valid, id_pc, id_instr,
        output id_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// IF stage for the 5-stage RV32 pipeline: owns the PC, issues reads to a
// 1-cycle synchronous instruction memory and queues {pc, instr} pairs in a
// small FIFO drained by ID. Supports redirect (full squash) and halt.
module fetch_queue_unit #(
    parameter int PC_W     = 9,
    parameter int INS_W    = 32,
    parameter int DEPTH    = 4,
    parameter int PC_STEP  = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    fetch_queue_unit_if.master         bus,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    input  logic                       halt,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PC_W-1:0] PC_INC  = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  tag_pc;
    logic             inflight;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [INS_W-1:0] ins_mem [DEPTH];

    logic [CNT_W:0]   credits_used;
    logic             issue;
    logic             push;
    logic             pop;

    // Issue credit, fill and drain decisions for the current cycle.
    always_comb begin
        // The inflight read already owns a FIFO slot, so it counts against
        // the credit; a same-cycle pop is deliberately not credited back.
        credits_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        issue        = !reset && !redirect && !halt && (credits_used < DEPTH_C);
        push         = inflight && !redirect;
        pop          = (count != '0) && bus.id_ready && !redirect;
    end

    assign bus.imem_rd_en = issue;
    assign bus.imem_addr  = fetch_pc;
    assign bus.id_valid   = (count != '0);
    assign bus.id_pc      = bus.id_valid ? pc_mem[rd_ptr]  : '0;
    assign bus.id_instr   = bus.id_valid ? ins_mem[rd_ptr] : '0;
    assign occupancy      = count;

    // PC, inflight tracking and FIFO pointer/count bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every branch reads
        // the pre-edge values of count, pointers and fetch_pc.
        if (reset) begin
            fetch_pc <= PC_RST;
            tag_pc   <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PC_INC;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write: capture the returning instruction with its PC.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; count gates id_valid and the outputs are
        // forced to zero when empty, so stale entries are never observable.
        if (push && !reset) begin
            pc_mem[wr_ptr]  <= tag_pc;
            ins_mem[wr_ptr] <= bus.imem_data;
        end
    end
endmodule
